// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: requester 0 is ALU writeback, requester 1 is load/memory
//   writeback. Each requester feeds its own FIFO_DEPTH-entry queue. A
//   round-robin arbiter pops one queue head per cycle into a registered
//   write stage (wb_en/wb_addr/wb_data). Decode-stage reads that hit a write
//   still sitting in a queue are flagged so decode can stall.
//
// Ports
//   clk                      clock, all state on rising edge
//   reset                    asynchronous, active-low (0 = in reset)
//   r0_valid/r0_ready        requester 0 handshake
//   r0_addr/r0_data          requester 0 destination register / data
//   r1_valid/r1_ready        requester 1 handshake
//   r1_addr/r1_data          requester 1 destination register / data
//   rd_addr1/rd_addr2        decode read addresses
//   rd_hazard1/rd_hazard2    read address matches a queued, not yet issued write
//   wb_en/wb_addr/wb_data    register-file write port
//   busy                     any queue non-empty or a write being issued
//
// Handshake: a transfer happens on a rising edge where rN_valid && rN_ready.
// rN_ready depends only on state (queue not full, not in reset), never on
// rN_valid, and a full queue does not accept even if it pops that cycle.
// A transfer to register 0 completes but is dropped (no entry, no write).
module regfile_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hazard1,
  output logic              rd_hazard2,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-requester queue storage and pointers (index 0 = ALU, 1 = load).
  logic [ADDR_W-1:0] q_addr [2][FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  count  [2];

  // 1 = requester 1 held the last grant, so requester 0 wins next contention.
  logic last_grant;

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_addr  [2];
  logic [DATA_W-1:0] in_data  [2];
  logic              ready    [2];
  logic              push     [2];
  logic              nonempty [2];
  logic              grant    [2];
  logic [ADDR_W-1:0] head_addr [2];
  logic [DATA_W-1:0] head_data [2];

  always_comb begin
    in_valid[0] = r0_valid;
    in_addr[0]  = r0_addr;
    in_data[0]  = r0_data;
    in_valid[1] = r1_valid;
    in_addr[1]  = r1_addr;
    in_data[1]  = r1_data;
    for (int i = 0; i < 2; i++) begin
      ready[i]     = reset && (count[i] != CNT_W'(FIFO_DEPTH));
      push[i]      = in_valid[i] && ready[i] && (in_addr[i] != '0);
      nonempty[i]  = (count[i] != '0);
      head_addr[i] = q_addr[i][rd_ptr[i]];
      head_data[i] = q_data[i][rd_ptr[i]];
    end
    // Round robin: a lone candidate wins; on contention the requester that
    // did not win last time goes.
    grant[0] = nonempty[0] && (!nonempty[1] || last_grant);
    grant[1] = nonempty[1] && !grant[0];
  end

  assign r0_ready = ready[0];
  assign r1_ready = ready[1];

  // Hazard scan covers every occupied slot, including heads popping this
  // cycle; the issued write in wb_* is covered by the regfile bypass.
  always_comb begin
    logic hit1;
    logic hit2;
    logic [PTR_W-1:0] idx;
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        idx = rd_ptr[i] + PTR_W'(k);
        if (CNT_W'(k) < count[i]) begin
          if (q_addr[i][idx] == rd_addr1) hit1 = 1'b1;
          if (q_addr[i][idx] == rd_addr2) hit2 = 1'b1;
        end
      end
    end
    rd_hazard1 = hit1 && (rd_addr1 != '0);
    rd_hazard2 = hit2 && (rd_addr2 != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      last_grant <= 1'b1;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
      end
      if (grant[0] || grant[1]) begin
        last_grant <= grant[1];
        wb_en      <= 1'b1;
        wb_addr    <= grant[1] ? head_addr[1] : head_addr[0];
        wb_data    <= grant[1] ? head_data[1] : head_data[0];
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

  // Queue payload needs no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_addr[i][wr_ptr[i]] <= in_addr[i];
        q_data[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  assign busy = nonempty[0] || nonempty[1] || wb_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int EW     = ADDR_W + DATA_W;

  logic              clk;
  logic              reset;
  logic              r0_valid, r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;
  logic              r1_valid, r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_data;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic              rd_hazard1, rd_hazard2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_hazard1(rd_hazard1), .rd_hazard2(rd_hazard2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [EW-1:0] mq0[$], mq1[$];     // model queues {addr,data}
  logic [EW-1:0] src0[$], src1[$];   // pending offers per requester
  logic [ADDR_W-1:0] log_addr[$];    // observed issued addresses
  int                log_cyc[$];
  bit                m_last;
  bit                m_wb_en;
  logic [ADDR_W-1:0] m_wb_addr;
  logic [DATA_W-1:0] m_wb_data;
  bit gap_en, rand_rd, saw_r1_full, obs_h1, obs_h2, obs_r0rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit queued(input logic [ADDR_W-1:0] a);
    bit hit = 0;
    foreach (mq0[i]) if (mq0[i][EW-1:DATA_W] == a) hit = 1;
    foreach (mq1[i]) if (mq1[i][EW-1:DATA_W] == a) hit = 1;
    return hit && (a != 0);
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a rising edge; drives inputs, checks combinational
  // outputs at the falling edge, advances the model, checks registers.
  task automatic step();
    bit mr0, mr1, acc0, acc1;
    r0_valid = (src0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    r1_valid = (src1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    if (src0.size() > 0) {r0_addr, r0_data} = src0[0];
    if (src1.size() > 0) {r1_addr, r1_data} = src1[0];
    if (rand_rd) begin
      rd_addr1 = ADDR_W'($urandom_range(0, 31));
      rd_addr2 = ADDR_W'($urandom_range(0, 31));
    end
    @(negedge clk);
    mr0 = mq0.size() < DEPTH;
    mr1 = mq1.size() < DEPTH;
    check("r0_ready", 64'(r0_ready), 64'(mr0));
    check("r1_ready", 64'(r1_ready), 64'(mr1));
    check("rd_hazard1", 64'(rd_hazard1), 64'(queued(rd_addr1)));
    check("rd_hazard2", 64'(rd_hazard2), 64'(queued(rd_addr2)));
    obs_h1 = rd_hazard1;
    obs_h2 = rd_hazard2;
    obs_r0rdy = r0_ready;
    if (!r1_ready) saw_r1_full = 1;
    acc0 = r0_valid && mr0;
    acc1 = r1_valid && mr1;
    @(posedge clk);
    cyc++;
    if (mq0.size() > 0 && (mq1.size() == 0 || m_last)) begin
      {m_wb_addr, m_wb_data} = mq0.pop_front();
      m_wb_en = 1; m_last = 0;
    end else if (mq1.size() > 0) begin
      {m_wb_addr, m_wb_data} = mq1.pop_front();
      m_wb_en = 1; m_last = 1;
    end else begin
      m_wb_en = 0;
    end
    if (acc0) begin
      if (src0[0][EW-1:DATA_W] != 0) mq0.push_back(src0[0]);
      void'(src0.pop_front());
    end
    if (acc1) begin
      if (src1[0][EW-1:DATA_W] != 0) mq1.push_back(src1[0]);
      void'(src1.pop_front());
    end
    #1;
    check("wb_en", 64'(wb_en), 64'(m_wb_en));
    check("wb_addr", 64'(wb_addr), 64'(m_wb_addr));
    check("wb_data", wb_data, m_wb_data);
    check("busy", 64'(busy), 64'(mq0.size() > 0 || mq1.size() > 0 || m_wb_en));
    if (wb_en) begin
      log_addr.push_back(wb_addr);
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || mq0.size() > 0 ||
            mq1.size() > 0 || m_wb_en) && n < budget) begin
      step();
      n++;
    end
    check("drain_budget", 64'(n < budget), 64'(1));
  endtask

  // Asserts reset, checks outputs immediately, releases at a falling edge.
  task automatic apply_reset(input int cycles);
    reset = 0;
    r0_valid = 0;
    r1_valid = 0;
    src0.delete(); src1.delete(); mq0.delete(); mq1.delete();
    m_last = 1; m_wb_en = 0; m_wb_addr = '0; m_wb_data = '0;
    #1;
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_wb_addr", 64'(wb_addr), 64'(0));
    check("rst_wb_data", wb_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_r0_ready", 64'(r0_ready), 64'(0));
    check("rst_r1_ready", 64'(r1_ready), 64'(0));
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    check("rel_r0_ready", 64'(r0_ready), 64'(1));
    check("rel_r1_ready", 64'(r1_ready), 64'(1));
    check("rel_wb_en", 64'(wb_en), 64'(0));
    check("rel_busy", 64'(busy), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] exp3 [8];
    logic [ADDR_W-1:0] r1_seen[$];
    exp3 = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    reset = 1; r0_valid = 0; r1_valid = 0;
    r0_addr = '0; r0_data = '0; r1_addr = '0; r1_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    gap_en = 0; rand_rd = 0;
    #1;

    // 1: reset and idle
    apply_reset(3);
    step();

    // 2: single r0 write, addr 5 data A5
    src0.push_back({5'd5, 64'hA5});
    step();
    check("t2_e_wb_en", 64'(wb_en), 64'(0));
    step();
    check("t2_wb_en", 64'(wb_en), 64'(1));
    check("t2_wb_addr", 64'(wb_addr), 64'(5));
    check("t2_wb_data", wb_data, 64'hA5);
    step();
    check("t2_after_wb_en", 64'(wb_en), 64'(0));
    check("t2_after_busy", 64'(busy), 64'(0));

    // 3: both requesters fed every cycle, fresh round-robin pointer
    apply_reset(1);
    for (int i = 0; i < 4; i++) begin
      src0.push_back({ADDR_W'(1 + i), 64'(100 + i)});
      src1.push_back({ADDR_W'(9 + i), 64'(200 + i)});
    end
    log_addr.delete(); log_cyc.delete();
    drain(50);
    check("t3_count", 64'(log_addr.size()), 64'(8));
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      check("t3_addr_seq", 64'(log_addr[i]), 64'(exp3[i]));
      check("t3_no_idle", 64'(log_cyc[i]), 64'(log_cyc[0] + i));
    end

    // 4: r1 fills under contention, third push waits, nothing lost
    saw_r1_full = 0;
    log_addr.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) src0.push_back({5'd3, 64'(300 + i)});
    for (int i = 0; i < 3; i++) src1.push_back({ADDR_W'(20 + i), 64'(400 + i)});
    drain(50);
    check("t4_r1_full_seen", 64'(saw_r1_full), 64'(1));
    foreach (log_addr[i]) if (log_addr[i] >= 16) r1_seen.push_back(log_addr[i]);
    check("t4_r1_count", 64'(r1_seen.size()), 64'(3));
    for (int i = 0; i < 3 && i < r1_seen.size(); i++)
      check("t4_r1_order", 64'(r1_seen[i]), 64'(20 + i));

    // 5: hazard on a queued write, addr-0 push is dropped
    rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    src1.push_back({5'd7, 64'h77});
    step();
    src0.push_back({5'd0, 64'hDEAD});
    step();
    check("t5_hazard1", 64'(obs_h1), 64'(1));
    check("t5_hazard2", 64'(obs_h2), 64'(0));
    check("t5_r0_ready", 64'(obs_r0rdy), 64'(1));
    check("t5_wb_addr", 64'(wb_addr), 64'(7));
    step();
    check("t5_issued_hazard1", 64'(obs_h1), 64'(0));
    check("t5_no_pulse", 64'(wb_en), 64'(0));
    rd_addr1 = '0;

    // 6: reset mid-operation discards queued and in-flight writes
    for (int i = 0; i < 4; i++) begin
      src0.push_back({ADDR_W'(1 + i), 64'(500 + i)});
      src1.push_back({ADDR_W'(16 + i), 64'(600 + i)});
    end
    repeat (3) step();
    check("t6_pre_wb_en", 64'(wb_en), 64'(1));
    #2;
    apply_reset(2);
    log_addr.delete(); log_cyc.delete();
    repeat (4) step();
    check("t6_no_stale", 64'(log_addr.size()), 64'(0));

    // random phase
    gap_en = 1; rand_rd = 1;
    for (int n = 0; n < 400; n++) begin
      if (src0.size() < 3 && $urandom_range(0, 1) == 1)
        src0.push_back({ADDR_W'($urandom_range(0, 15)), 64'({$urandom, $urandom})});
      if (src1.size() < 3 && $urandom_range(0, 1) == 1)
        src1.push_back({($urandom_range(0, 9) == 0) ? ADDR_W'(0) : ADDR_W'($urandom_range(16, 31)),
                        64'({$urandom, $urandom})});
      step();
    end
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
